fetch_decode_alu: RTL and testbench
===================================

// Module: fetch_decode_alu
// PURPOSE
//   Single-cycle CPU front end: PC register (fetcher), MIPS-style decoder, 32-bit ALU.
//   Receives the instruction word at the current PC and splits it into fields.
//   Computes ALU results from register operands supplied by the parent cpu.
//   Computes the next PC, including taken branches and jumps.
//   Register file and data RAM sit in the parent cpu; this block holds only the PC.
// PARAMETERS
//   RESET_PC  32'h0  PC value loaded on reset (word address).
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   pc         out  32  word address of the current instruction
//   instr      in   32  instruction word at pc (combinational memory read)
//   opcode     out  6   instr[31:26]
//   rs         out  5   instr[25:21]
//   rt         out  5   instr[20:16]
//   rd         out  5   instr[15:11]
//   shamt      out  5   instr[10:6]
//   funct      out  6   instr[5:0]
//   imm        out  16  instr[15:0]
//   addr       out  26  instr[25:0]
//   imm_sext   out  32  imm sign-extended; used by parent for lw/sw rs+imm
//   is_rtype   out  1   opcode==6'h00
//   is_lw      out  1   opcode==6'h23
//   is_sw      out  1   opcode==6'h2B
//   is_beq     out  1   opcode==6'h04
//   is_j       out  1   opcode==6'h02
//   illegal    out  1   any other opcode, or R-type with unsupported funct
//   a, b       in   32  ALU operands (parent drives reg[rs], reg[rt])
//   out        out  32  ALU result
//   eq         out  1   a==b
// BEHAVIOUR
//   - One clock, clk; rst asynchronous active-high; pc=RESET_PC while rst is high, immediately.
//   - Only pc is state; all other outputs are combinational from instr, a, b, pc. Zero-latency decode and ALU.
//   - Next-pc priority, evaluated each posedge:
//     - is_j: pc <= {6'b0, addr}.
//     - is_beq and eq: pc <= {16'b0, imm} (absolute, not PC-relative).
//     - otherwise: pc <= pc+1 (word addressing), wrapping 32'hFFFFFFFF -> 0.
//   - Illegal instructions advance pc+1 and raise illegal; no trap.
//   - ALU selected by funct (arithmetic is mod 2^32; no overflow exceptions):
//     - Add/sub: 20 add, 21 addu, 22 sub (a-b), 23 subu.
//     - Logic: 24 and, 25 or, 26 xor, 27 nor.
//     - Compare: 2A slt (signed), 2B sltu (unsigned); result is 32'h1 or 0.
//     - Shift by shamt: 00 sll b<<shamt, 02 srl b>>shamt, 03 sra b>>>shamt.
//     - Shift by a[4:0]: 04 sllv, 06 srlv, 07 srav (b shifted).
//     - Other funct: out=0.
//   - ALU output is valid whatever the opcode; parent writes it to reg[rd] only when is_rtype.
//   - instr=0 decodes as sll $0,$0,0 (nop): is_rtype=1, illegal=0.
// STRUCTURE
//   - Package fda_pkg: OPC_* opcode and FN_* funct localparams, field-width constants.
//   - Sub-module alu: out=f(a,b,shamt,funct). The top holds the PC register, next-PC mux and decode logic.
// TESTING
//   - Reset: rst=1 -> pc=0 with no clock edge. Release, instr=0 for 3 clocks -> pc=1,2,3; illegal=0.
//   - Decode: instr=0x012A4020, a=5, b=7
//     -> rs=9, rt=10, rd=8, funct=0x20, is_rtype=1, out=12.
//   - ALU edge cases:
//     - sub a=3, b=5 -> 0xFFFFFFFE.
//     - sltu a=1, b=0xFFFFFFFF -> 1; slt on the same operands -> 0.
//     - sra b=0x80000000, shamt=4 -> 0xF8000000.
//   - Jump: instr=0x08000010 -> is_j=1; next pc=0x10.
//   - Branch: instr=0x11090020 with a=b=9 -> pc=0x20. Same instr with a=1, b=2 -> pc+1.
//   - Mid-run reset: pc=0x20, assert rst between edges -> pc=0 immediately; held through edges until release.
//   - Illegal: instr=0xFC000000 -> illegal=1; pc+1.

Source files
------------

// File: rtl/fda_pkg.sv
// Shared opcode/funct encodings and field widths for the fetch/decode/ALU front end.
package fda_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPC_W      = 6;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned ADDR_W     = 26;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_SLLV = 6'h04;
  localparam logic [FUNCT_W-1:0] FN_SRLV = 6'h06;
  localparam logic [FUNCT_W-1:0] FN_SRAV = 6'h07;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

  // True for every funct the ALU implements; anything else is an illegal R-type.
  function automatic logic fn_supported(input logic [FUNCT_W-1:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_alu_alu.sv
// Combinational 32-bit ALU selected by funct; wraps mod 2^32, no overflow traps.
module alu
  import fda_pkg::*;
(
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [FUNCT_W-1:0] funct,
  output logic [XLEN-1:0]    out
);

  always_comb begin
    out = '0;
    case (funct)
      FN_ADD, FN_ADDU: out = a + b;
      FN_SUB, FN_SUBU: out = a - b;
      FN_AND:          out = a & b;
      FN_OR:           out = a | b;
      FN_XOR:          out = a ^ b;
      FN_NOR:          out = ~(a | b);
      FN_SLT:          out = {31'b0, $signed(a) < $signed(b)};
      FN_SLTU:         out = {31'b0, a < b};
      FN_SLL:          out = b << shamt;
      FN_SRL:          out = b >> shamt;
      FN_SRA:          out = XLEN'($signed(b) >>> shamt);
      // Variable shifts take their amount from the low bits of a.
      FN_SLLV:         out = b << a[4:0];
      FN_SRLV:         out = b >> a[4:0];
      FN_SRAV:         out = XLEN'($signed(b) >>> a[4:0]);
      default:         out = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_alu.sv
// Single-cycle CPU front end: PC register, instruction field decode and ALU.
module fetch_decode_alu
  import fda_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     instr,
  output logic [OPC_W-1:0]    opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [IMM_W-1:0]    imm,
  output logic [ADDR_W-1:0]   addr,
  output logic [XLEN-1:0]     imm_sext,
  output logic                is_rtype,
  output logic                is_lw,
  output logic                is_sw,
  output logic                is_beq,
  output logic                is_j,
  output logic                illegal,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     out,
  output logic                eq
);

  logic [XLEN-1:0] next_pc;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign addr     = instr[25:0];
  assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

  assign is_rtype = (opcode == OPC_RTYPE);
  assign is_lw    = (opcode == OPC_LW);
  assign is_sw    = (opcode == OPC_SW);
  assign is_beq   = (opcode == OPC_BEQ);
  assign is_j     = (opcode == OPC_J);
  assign illegal  = is_rtype ? !fn_supported(funct)
                             : !(is_lw || is_sw || is_beq || is_j);

  assign eq = (a == b);

  alu u_alu (
    .a     (a),
    .b     (b),
    .shamt (shamt),
    .funct (funct),
    .out   (out)
  );

  // Jump beats branch; both targets are absolute word addresses.
  always_comb begin
    next_pc = pc + 32'd1;
    if (is_j)
      next_pc = {6'b0, addr};
    else if (is_beq && eq)
      next_pc = {16'b0, imm};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Directed bench: expectations are queued when stimulus is applied and popped when outputs are sampled.
module tb_fetch_decode_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] addr;
  logic [31:0] imm_sext;
  logic        is_rtype, is_lw, is_sw, is_beq, is_j, illegal;
  logic [31:0] a, b, out;
  logic        eq;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_decode_alu #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .addr(addr), .imm_sext(imm_sext),
    .is_rtype(is_rtype), .is_lw(is_lw), .is_sw(is_sw), .is_beq(is_beq),
    .is_j(is_j), .illegal(illegal),
    .a(a), .b(b), .out(out), .eq(eq)
  );

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       tag;
    logic [31:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      tag  = tag_q.pop_front();
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
    end
  endtask

  // One active edge, then settle away from it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; a = 32'h0; b = 32'h0;

    // Async reset visible before any clock edge
    #2;
    expect_v("reset_pc", 32'h0);
    check_v(pc);
    tick();
    expect_v("reset_hold_pc", 32'h0);
    check_v(pc);
    rst = 1'b0;

    // nop sequence increments pc
    for (int i = 1; i <= 3; i++) begin
      expect_v($sformatf("nop_pc_%0d", i), 32'(i));
      expect_v("nop_illegal", 32'h0);
      expect_v("nop_rtype", 32'h1);
      tick();
      check_v(pc);
      check_v(32'(illegal));
      check_v(32'(is_rtype));
    end

    // Field decode and add
    instr = 32'h012A4020; a = 32'd5; b = 32'd7;
    expect_v("dec_rs", 32'd9);
    expect_v("dec_rt", 32'd10);
    expect_v("dec_rd", 32'd8);
    expect_v("dec_shamt", 32'd0);
    expect_v("dec_funct", 32'h20);
    expect_v("dec_imm", 32'h4020);
    expect_v("dec_addr", 32'h012A4020);
    expect_v("dec_rtype", 32'h1);
    expect_v("dec_opcode", 32'h0);
    expect_v("add_out", 32'd12);
    expect_v("dec_eq", 32'h0);
    #1;
    check_v(32'(rs)); check_v(32'(rt)); check_v(32'(rd));
    check_v(32'(shamt)); check_v(32'(funct)); check_v(32'(imm));
    check_v(32'(addr)); check_v(32'(is_rtype)); check_v(32'(opcode));
    check_v(out); check_v(32'(eq));

    // ALU edge cases
    instr = 32'h00000022; a = 32'd3; b = 32'd5;
    expect_v("sub_out", 32'hFFFFFFFE); #1; check_v(out);
    instr = 32'h0000002B; a = 32'd1; b = 32'hFFFFFFFF;
    expect_v("sltu_out", 32'h1); #1; check_v(out);
    instr = 32'h0000002A;
    expect_v("slt_out", 32'h0); #1; check_v(out);
    instr = 32'h00000103; b = 32'h80000000;
    expect_v("sra_out", 32'hF8000000); #1; check_v(out);
    instr = 32'h00000102; // srl by 4
    expect_v("srl_out", 32'h08000000); #1; check_v(out);
    instr = 32'h00000007; a = 32'h00000024; b = 32'h80000000; // srav uses a[4:0]=4
    expect_v("srav_out", 32'hF8000000); #1; check_v(out);
    instr = 32'h00000004; a = 32'd8; b = 32'h000000F1;
    expect_v("sllv_out", 32'h0000F100); #1; check_v(out);
    instr = 32'h00000027; a = 32'h0F0F0000; b = 32'h000000F0;
    expect_v("nor_out", 32'hF0F0FF0F); #1; check_v(out);
    instr = 32'h00000026; a = 32'hFF00FF00; b = 32'h0FF00FF0;
    expect_v("xor_out", 32'hF0F0F0F0); #1; check_v(out);
    instr = 32'h00000024;
    expect_v("and_out", 32'h0F000F00); #1; check_v(out);
    instr = 32'h00000001; // unsupported funct
    expect_v("badfn_out", 32'h0);
    expect_v("badfn_illegal", 32'h1);
    #1; check_v(out); check_v(32'(illegal));

    // Load/store decode with sign extension
    instr = 32'h8C01FFFC;
    expect_v("lw_is_lw", 32'h1);
    expect_v("lw_imm_sext", 32'hFFFFFFFC);
    expect_v("lw_illegal", 32'h0);
    #1; check_v(32'(is_lw)); check_v(imm_sext); check_v(32'(illegal));
    instr = 32'hAC007FFF;
    expect_v("sw_is_sw", 32'h1);
    expect_v("sw_imm_sext", 32'h00007FFF);
    #1; check_v(32'(is_sw)); check_v(imm_sext);

    // Jump
    instr = 32'h08000010;
    expect_v("j_is_j", 32'h1);
    expect_v("j_pc", 32'h10);
    #1; check_v(32'(is_j));
    tick(); check_v(pc);

    // Branch taken and not taken
    instr = 32'h11090020; a = 32'd9; b = 32'd9;
    expect_v("beq_is_beq", 32'h1);
    expect_v("beq_taken_pc", 32'h20);
    #1; check_v(32'(is_beq));
    tick(); check_v(pc);
    a = 32'd1; b = 32'd2;
    expect_v("beq_not_taken_pc", 32'h21);
    tick(); check_v(pc);

    // Mid-run reset between edges
    a = 32'd9; b = 32'd9;
    expect_v("pre_reset_pc", 32'h20);
    tick(); check_v(pc);
    #2 rst = 1'b1;
    expect_v("midrun_reset_pc", 32'h0);
    #1; check_v(pc);
    for (int i = 0; i < 2; i++) begin
      expect_v("reset_held_pc", 32'h0);
      tick(); check_v(pc);
    end
    rst = 1'b0; instr = 32'h0;
    expect_v("post_reset_pc", 32'h1);
    tick(); check_v(pc);

    // Illegal opcode advances pc
    instr = 32'hFC000000;
    expect_v("illegal_flag", 32'h1);
    expect_v("illegal_pc", 32'h2);
    #1; check_v(32'(illegal));
    tick(); check_v(pc);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
